// File: rtl/ex_muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit_pkg
// Shared pipeline definitions for the EX-stage multiply/divide unit: the
// MULT/MULTU/DIV/DIVU op encodings, the sequencer state encodings and small
// helpers used when operands enter and results leave the iterative datapath.
// ---------------------------------------------------------------------------
package ex_muldiv_unit_pkg;

  // Operation encodings as decoded by the control unit.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Sequencer state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX
  } muldivState;

  // One shift-add or restore step per cycle, one step per operand bit.
  localparam int ITERATIONS = 32;

  // Absolute value for signed ops, raw value for unsigned ops.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] value,
                                            input logic        isSigned);
    return (isSigned && value[31]) ? (~value + 32'd1) : value;
  endfunction

  // Two's-complement negate when the flag is set.
  function automatic logic [31:0] negateIf(input logic [31:0] value,
                                           input logic        neg);
    return neg ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
// Purely combinational single iteration of the multiply/divide datapath.
//   isDiv    in   1  0: shift-add multiply step, 1: restoring divide step
//   remIn    in  32  multiply: upper product half / divide: partial remainder
//   lowIn    in  32  multiply: multiplier + low product bits / divide:
//                    remaining dividend bits shifting out, quotient shifting in
//   operand  in  32  multiply: multiplicand / divide: divisor (magnitudes)
//   remOut   out 32  next value of remIn
//   lowOut   out 32  next value of lowIn
// ---------------------------------------------------------------------------
module muldiv_step (
  input  logic        isDiv,
  input  logic [31:0] remIn,
  input  logic [31:0] lowIn,
  input  logic [31:0] operand,
  output logic [31:0] remOut,
  output logic [31:0] lowOut
);

  logic [32:0] sum;       // upper half plus conditional multiplicand, with carry
  logic [32:0] partial;   // 33-bit partial remainder after shifting in one bit
  logic        fits;      // divisor fits into the partial remainder

  // NOTE: every output of a combinational block gets a default assignment
  // first so that no path leaves a value held, which would infer a latch.
  always_comb begin
    sum     = '0;
    partial = '0;
    fits    = 1'b0;
    remOut  = remIn;
    lowOut  = lowIn;
    if (isDiv) begin
      partial = {remIn, lowIn[31]};
      fits    = (partial >= {1'b0, operand});
      // When the divisor fits the true difference is below 2^32, so the
      // 32-bit wrap-around subtraction gives the exact new remainder.
      remOut  = fits ? (partial[31:0] - operand) : partial[31:0];
      lowOut  = {lowIn[30:0], fits};
    end else begin
      sum    = {1'b0, remIn} + (lowIn[0] ? {1'b0, operand} : 33'd0);
      // Shift the whole {carry, upper, lower} accumulator right by one.
      remOut = sum[32:1];
      lowOut = {sum[0], lowIn[31:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative EX-stage multiply/divide unit owning the HI/LO registers.
// Sequence: IDLE -> CALC (32 iterations) -> FIX (sign fix-up, HI/LO write).
// done is seen 34 cycles after the start edge.
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous active-low reset
//   start    in   1  MULT/MULTU/DIV/DIVU issue from EX
//   op       in   2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a        in  32  rs operand (forwarded)
//   b        in  32  rt operand (forwarded)
//   kill     in   1  EX flush, aborts any operation, highest priority
//   wr_hi    in   1  MTHI write enable (honoured only in IDLE)
//   wr_lo    in   1  MTLO write enable (honoured only in IDLE)
//   wr_data  in  32  MTHI/MTLO data
//   rd_hilo  in   1  MFHI/MFLO present in EX
//   hi       out 32  HI register
//   lo       out 32  LO register
//   busy     out  1  operation in progress (CALC or FIX)
//   done     out  1  one-cycle pulse after HI/LO are committed
//   stall    out  1  hold IF/ID/ID_EX while a HI/LO user waits on busy
// ---------------------------------------------------------------------------
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        kill,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  input  logic        rd_hilo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam logic [5:0] LAST_COUNT = 6'(ITERATIONS - 1);

  muldivState  state;
  logic        isDivReg;
  logic        resNeg;      // quotient / product must be negated
  logic        remNeg;      // remainder must be negated (sign of dividend)
  logic        divZero;
  logic [31:0] operandReg;  // multiplicand or divisor magnitude
  logic [31:0] accHi;
  logic [31:0] accLo;
  logic [5:0]  count;

  logic        opIsDiv;
  logic        opIsSigned;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] stepHi;
  logic [31:0] stepLo;
  logic [31:0] fixHi;
  logic [31:0] fixLo;

  always_comb begin
    opIsDiv    = 1'b0;
    opIsSigned = 1'b0;
    case (op)
      OP_MULT:  begin opIsDiv = 1'b0; opIsSigned = 1'b1; end
      OP_MULTU: begin opIsDiv = 1'b0; opIsSigned = 1'b0; end
      OP_DIV:   begin opIsDiv = 1'b1; opIsSigned = 1'b1; end
      OP_DIVU:  begin opIsDiv = 1'b1; opIsSigned = 1'b0; end
      default:  begin opIsDiv = 1'b0; opIsSigned = 1'b0; end
    endcase
  end

  assign magA = magnitude(a, opIsSigned);
  assign magB = magnitude(b, opIsSigned);

  // Dividend/multiplier enters in accLo, divisor/multiplicand in operandReg;
  // multiplication is commutative so both ops share one loading scheme.
  muldiv_step uStep (
    .isDiv   (isDivReg),
    .remIn   (accHi),
    .lowIn   (accLo),
    .operand (operandReg),
    .remOut  (stepHi),
    .lowOut  (stepLo)
  );

  // Sign fix-up applied on the way into HI/LO.
  always_comb begin
    logic [63:0] product;
    product = {accHi, accLo};
    fixHi   = accHi;
    fixLo   = accLo;
    if (isDivReg) begin
      // Divide by zero: the restoring loop already leaves |a| as remainder,
      // so only the quotient needs forcing to all ones.
      fixLo = divZero ? 32'hFFFF_FFFF : negateIf(accLo, resNeg);
      fixHi = negateIf(accHi, remNeg);
    end else begin
      if (resNeg) begin
        product = ~product + 64'd1;
      end
      {fixHi, fixLo} = product;
    end
  end

  assign stall = busy & (rd_hilo | start | wr_hi | wr_lo);

  // NOTE: sequential state is assigned with <= only, so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: every register here, operand and accumulator included, is cleared
  // by reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      isDivReg   <= 1'b0;
      resNeg     <= 1'b0;
      remNeg     <= 1'b0;
      divZero    <= 1'b0;
      operandReg <= '0;
      accHi      <= '0;
      accLo      <= '0;
      count      <= '0;
      hi         <= '0;
      lo         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (kill) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Start wins over a simultaneous MTHI/MTLO, which is dropped.
            isDivReg   <= opIsDiv;
            resNeg     <= opIsSigned & (a[31] ^ b[31]);
            remNeg     <= opIsSigned & a[31];
            divZero    <= opIsDiv & (b == 32'd0);
            operandReg <= magB;
            accHi      <= '0;
            accLo      <= magA;
            count      <= '0;
            busy       <= 1'b1;
            state      <= CALC;
          end else begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
          end
        end
        CALC: begin
          accHi <= stepHi;
          accLo <= stepLo;
          count <= count + 6'd1;
          if (count == LAST_COUNT) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi    <= fixHi;
          lo    <= fixLo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Directed and lightly randomised bench for ex_muldiv_unit. Expected HI/LO
// pairs are queued when an operation is issued and popped when done pulses.
// Cycle numbering: cycle 0 is the cycle in which start is presented.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        rd_hilo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] expQ[$];

  ex_muldiv_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .kill    (kill),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wr_data (wr_data),
    .rd_hilo (rd_hilo),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour written directly from the architectural definition.
  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [63:0] sp;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    case (o)
      2'b00: begin
        sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        return sp;
      end
      2'b01: return {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Wait (bounded) for done, expecting it in cycle 34, then score HI/LO.
  task automatic waitDone(input string tag);
    int n;
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd34);
    if (expQ.size() > 0) check({tag, " result"}, {hi, lo}, expQ.pop_front());
    else check({tag, " scoreboard"}, 64'(expQ.size()), 64'd1);
    tick();
    check({tag, " done pulse"}, {62'd0, busy, done}, 64'd0);
  endtask

  task automatic runOp(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] expv,
                       input string tag);
    op = o; a = x; b = y; start = 1'b1;
    expQ.push_back(expv);
    tick();
    start = 1'b0;
    waitDone(tag);
  endtask

  initial begin
    logic [31:0] keepHi;
    logic [31:0] keepLo;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        doneSeen;

    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; kill = 1'b0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0; rd_hilo = 1'b0;

    // Reset state before any clock edge.
    #2;
    check("reset hilo", {hi, lo}, 64'd0);
    check("reset flags", {61'd0, busy, done, stall}, 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // MTHI alone, then MTHI+MTLO together.
    wr_hi = 1'b1; wr_data = 32'h1234_5678;
    tick();
    wr_hi = 1'b0;
    check("mthi", {hi, lo}, {32'h1234_5678, 32'd0});
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hA5A5_0F0F;
    tick();
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("mthi+mtlo", {hi, lo}, {32'hA5A5_0F0F, 32'hA5A5_0F0F});

    // Architectural vectors.
    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, "multu max");
    runOp(2'b00, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, "mult -3*7");
    runOp(2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div -7/2");
    runOp(2'b11, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, "divu by 0");
    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, "div overflow");
    runOp(2'b10, 32'hFFFF_FF9C, 32'd0, {32'hFFFF_FF9C, 32'hFFFF_FFFF}, "div -100 by 0");
    runOp(2'b00, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'd0}, "mult min*min");
    runOp(2'b10, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, "div 7/-2");

    // Random operations against the reference model.
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i == 7) rb = 32'd0;
      runOp(ro, ra, rb, model(ro, ra, rb), $sformatf("random %0d op%0d", i, ro));
    end

    // Hazards: MFHI from cycle 5, second start at cycle 10 while busy.
    op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
    expQ.push_back({32'd6, 32'd142});
    tick();
    start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      rd_hilo = (c >= 5);
      start   = (c == 10);
      if (c == 10) begin op = 2'b00; a = 32'd5; b = 32'd5; end
      #1;
      if (c >= 5) check($sformatf("stall cycle %0d", c), 64'(stall), 64'(c <= 33));
      if (c == 34) begin
        check("hazard done", 64'(done), 64'd1);
        if (expQ.size() > 0) check("hazard result", {hi, lo}, expQ.pop_front());
      end
      start = 1'b0;
      if (c < 34) tick();
    end
    rd_hilo = 1'b0;
    tick();
    check("second start ignored", {62'd0, busy, done}, 64'd0);

    // Start together with MTHI in IDLE: start wins, write is dropped.
    keepHi = hi;
    op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
    wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
    expQ.push_back({32'd0, 32'd6});
    tick();
    start = 1'b0; wr_hi = 1'b0;
    check("start over mthi", {31'd0, busy, hi}, {31'd0, 1'b1, keepHi});
    waitDone("multu 2*3");

    // Kill in cycle 12 of a DIV.
    keepHi = hi; keepLo = lo;
    op = 2'b10; a = 32'hFFFF_0000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 12; c++) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill to idle", {63'd0, busy}, 64'd0);
    doneSeen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      doneSeen = doneSeen | done;
      tick();
    end
    check("kill no done", 64'(doneSeen), 64'd0);
    check("kill hilo kept", {hi, lo}, {keepHi, keepLo});

    // Kill together with start in IDLE starts nothing.
    op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1; kill = 1'b1;
    tick();
    start = 1'b0; kill = 1'b0;
    check("kill+start idle", {63'd0, busy}, 64'd0);

    // Asynchronous reset in cycle 20 of a MULTU.
    op = 2'b01; a = 32'hFFFF; b = 32'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rd_hilo = 1'b1;
    #1;
    check("pre-reset stall", 64'(stall), 64'd1);
    rst = 1'b0;
    #1;
    check("async reset hilo", {hi, lo}, 64'd0);
    check("async reset flags", {61'd0, busy, done, stall}, 64'd0);
    tick();
    tick();
    rst = 1'b1; rd_hilo = 1'b0;
    runOp(2'b01, 32'd3, 32'd5, {32'd0, 32'd15}, "after reset");

    check("scoreboard empty", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
